// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked sequential adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Minimum width of 1 so a single-chunk build still gets a usable counter.
  function automatic int idx_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple-carry adder built from full-adder cells.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] c_s;

  assign c_s[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]     = x[i] ^ y[i] ^ c_s[i];
    assign c_s[i+1] = (x[i] & y[i]) | (c_s[i] & (x[i] ^ y[i]));
  end

  assign co       = c_s[CHUNK];
  // Carry entering the top bit; XOR with co gives signed overflow.
  assign c_msb_in = c_s[CHUNK-1];

endmodule

// File: rtl/seq_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per cycle, LS chunk first,
// with valid/ready on both sides and a held result.
module seq_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = idx_width(NCHUNK);
  localparam int LW     = idx_width(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("seq_adder: WIDTH must be a multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic [LW-1:0]    lo_s;
  logic [CHUNK-1:0] x_s, y_s, s_s;
  logic             co_s, c_msb_s;
  logic             last_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_s)    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE);
  end

  // Select the active chunk of both latched operands.
  always_comb begin
    lo_s   = LW'(idx_q) * LW'(CHUNK);
    x_s    = a_q[lo_s +: CHUNK];
    y_s    = b_q[lo_s +: CHUNK];
    last_s = (idx_q == LAST_IDX);
  end

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .x        (x_s),
    .y        (y_s),
    .ci       (carry_q),
    .s        (s_s),
    .co       (co_s),
    .c_msb_in (c_msb_s)
  );

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1, so fold the inversion in at capture.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
        end
      end
      RUN: begin
        sum_d[lo_s +: CHUNK] = s_s;
        carry_d              = co_s;
        if (last_s) begin
          cout_d      = co_s;
          ovf_d       = co_s ^ c_msb_s;
          out_valid_d = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_adder.sv
// Scoreboard bench for seq_adder with CHUNK = 4, 16 and 1 (WIDTH = 16).
module tb_seq_adder;

  localparam int NCFG = 3;
  localparam int CH  [NCFG] = '{4, 16, 1};
  localparam int NCH [NCFG] = '{4, 1, 16};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid_s  [NCFG];
  logic        in_ready_s  [NCFG];
  logic [15:0] a_s         [NCFG];
  logic [15:0] b_s         [NCFG];
  logic        cin_s       [NCFG];
  logic        sub_s       [NCFG];
  logic        out_valid_s [NCFG];
  logic        out_ready_s [NCFG];
  logic [15:0] sum_s       [NCFG];
  logic        cout_s      [NCFG];
  logic        ovf_s       [NCFG];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    seq_adder #(.WIDTH(16), .CHUNK(CH[g])) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_s[g]),
      .in_ready  (in_ready_s[g]),
      .a         (a_s[g]),
      .b         (b_s[g]),
      .cin       (cin_s[g]),
      .sub       (sub_s[g]),
      .out_valid (out_valid_s[g]),
      .out_ready (out_ready_s[g]),
      .sum       (sum_s[g]),
      .cout      (cout_s[g]),
      .ovf       (ovf_s[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, sum}; overflow from operand/result signs.
  function automatic logic [17:0] model(input logic [15:0] av, input logic [15:0] bv,
                                        input logic c, input logic s);
    logic [15:0] bb;
    logic [16:0] r;
    logic        ci;
    logic        ov;
    bb = s ? ~bv : bv;
    ci = s ? 1'b1 : c;
    r  = {1'b0, av} + {1'b0, bb} + {16'd0, ci};
    ov = (av[15] == bb[15]) && (r[15] != av[15]);
    return {ov, r[16], r[15:0]};
  endfunction

  function automatic logic [17:0] res(input int g);
    return {ovf_s[g], cout_s[g], sum_s[g]};
  endfunction

  task automatic wait_ready(input int g, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready_s[g] && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_s[g]) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_op(input int g, input logic [15:0] av, input logic [15:0] bv,
                        input logic c, input logic s, input string tag);
    logic [17:0] exp;
    int n;
    exp = model(av, bv, c, s);
    wait_ready(g, tag);
    a_s[g] = av; b_s[g] = bv; cin_s[g] = c; sub_s[g] = s;
    in_valid_s[g] = 1'b1; out_ready_s[g] = 1'b0;
    @(posedge clk); #1;
    in_valid_s[g] = 1'b0;
    a_s[g] = ~av; b_s[g] = 16'h5A5A; cin_s[g] = ~c; sub_s[g] = ~s;
    n = 0;
    while (!out_valid_s[g] && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, NCH[g]);
    check({tag, "_result"}, res(g), exp);
    out_ready_s[g] = 1'b1;
    @(posedge clk); #1;
    check({tag, "_drain"}, {out_valid_s[g], in_ready_s[g]}, 2'b01);
    out_ready_s[g] = 1'b0;
  endtask

  task automatic run_random(input int g);
    logic [17:0] q[$];
    logic [17:0] prev;
    logic [17:0] exp;
    logic        hold_prev;
    logic        ivl, ovr;
    logic [15:0] av, bv;
    logic        c, s;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; hold_prev = 1'b0; prev = '0;
    while (got < 200 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (hold_prev) begin
        check($sformatf("rnd%0d_hold_valid", g), out_valid_s[g], 1'b1);
        check($sformatf("rnd%0d_hold_data", g), res(g), prev);
      end
      av  = 16'($urandom);
      bv  = 16'($urandom);
      c   = 1'($urandom);
      s   = 1'($urandom);
      ovr = ($urandom_range(0, 3) != 0);
      ivl = (sent < 200) && ($urandom_range(0, 1) == 1);
      a_s[g] = av; b_s[g] = bv; cin_s[g] = c; sub_s[g] = s;
      in_valid_s[g] = ivl; out_ready_s[g] = ovr;
      if (in_ready_s[g] && ivl) begin
        q.push_back(model(av, bv, c, s));
        sent++;
      end
      if (out_valid_s[g] && ovr) begin
        if (q.size() == 0) begin
          check($sformatf("rnd%0d_unexpected_result", g), 32'd0, 32'd1);
        end else begin
          exp = q.pop_front();
          check($sformatf("rnd%0d_result_%0d", g, got), res(g), exp);
        end
        got++;
      end
      hold_prev = out_valid_s[g] && !ovr;
      prev      = res(g);
    end
    in_valid_s[g] = 1'b0; out_ready_s[g] = 1'b1;
    check($sformatf("rnd%0d_count", g), got, 200);
    check($sformatf("rnd%0d_leftover", g), q.size(), 0);
    repeat (NCH[g] + 4) @(posedge clk);
    #1;
    check($sformatf("rnd%0d_no_extra", g), out_valid_s[g], 1'b0);
    out_ready_s[g] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NCFG; i++) begin
      in_valid_s[i] = 1'b0; out_ready_s[i] = 1'b0;
      a_s[i] = '0; b_s[i] = '0; cin_s[i] = 1'b0; sub_s[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {out_valid_s[0], res(0)}, 19'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_in_ready", in_ready_s[0], 1'b1);

    run_op(0, 16'h1234, 16'h0FF0, 1'b0, 1'b0, "add_basic");
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, "add_wrap");
    run_op(0, 16'h7FFF, 16'h0000, 1'b1, 1'b0, "add_ovf");
    run_op(0, 16'h0005, 16'h0007, 1'b1, 1'b1, "sub_borrow");
    run_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, "sub_ovf");
    check("const_sum_ovf", model(16'h8000, 16'h0001, 1'b0, 1'b1), 18'h37FFF);

    // Back-pressure with a competing request waiting in DONE.
    wait_ready(0, "bp");
    a_s[0] = 16'h1111; b_s[0] = 16'h2222; cin_s[0] = 1'b0; sub_s[0] = 1'b0;
    in_valid_s[0] = 1'b1;
    @(posedge clk); #1;
    a_s[0] = 16'h0100; b_s[0] = 16'h0200;
    repeat (NCH[0]) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_hold_%0d", i), {out_valid_s[0], in_ready_s[0], res(0)},
            {1'b1, 1'b0, model(16'h1111, 16'h2222, 1'b0, 1'b0)});
      @(posedge clk); #1;
    end
    out_ready_s[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {out_valid_s[0], in_ready_s[0]}, 2'b01);
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    check("bp_accept_next", in_ready_s[0], 1'b0);
    repeat (NCH[0]) @(posedge clk);
    #1;
    check("bp_next_result", {out_valid_s[0], res(0)},
          {1'b1, model(16'h0100, 16'h0200, 1'b0, 1'b0)});
    @(posedge clk); #1;
    out_ready_s[0] = 1'b0;

    // Reset in the middle of RUN.
    wait_ready(0, "rst_mid");
    a_s[0] = 16'h1234; b_s[0] = 16'h1111; in_valid_s[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_state", {out_valid_s[0], in_ready_s[0], sum_s[0]}, {1'b0, 1'b1, 16'h0000});
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("rst_mid_quiet_%0d", i), out_valid_s[0], 1'b0);
    end
    run_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0, "rst_next");

    run_op(1, 16'h7FFF, 16'h0000, 1'b1, 1'b0, "c16_add_ovf");
    run_op(2, 16'h8000, 16'h0001, 1'b0, 1'b1, "c1_sub_ovf");

    for (int g = 0; g < NCFG; g++) run_random(g);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
